// File: rtl/aemb2_pkg.sv
// Shared definitions for the aeMB2 instruction fetch stage.
// Latency: none (constants, types and a pure decode function only).
// Backpressure: not applicable.
// Contents: opcode/branch constants, instruction field positions, default
// reset vectors, fetch FSM state type and the IF field bundle with its decoder.
package aemb2_pkg;

    localparam logic [5:0]  OPC_NOP   = 6'o40;
    localparam logic [1:0]  BRA_NODLY = 2'b10;   // taken branch without delay slot

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 21;
    localparam int RA_MSB  = 20;
    localparam int RA_LSB  = 16;
    localparam int RB_MSB  = 15;
    localparam int RB_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    localparam logic [29:0] RPC0_DEF = 30'h0;
    localparam logic [29:0] RPC1_DEF = 30'h100;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } if_state_t;

    typedef struct packed {
        logic [5:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [15:0] imm;
    } if_fields_t;

    localparam if_fields_t IF_NOP = '{opc: OPC_NOP, default: '0};

    function automatic if_fields_t decode_word(input logic [31:0] w);
        if_fields_t f;
        f.opc = w[OPC_MSB:OPC_LSB];
        f.rd  = w[RD_MSB:RD_LSB];
        f.ra  = w[RA_MSB:RA_LSB];
        f.rb  = w[RB_MSB:RB_LSB];
        f.imm = w[IMM_MSB:IMM_LSB];
        return f;
    endfunction

endpackage

// File: rtl/aemb2_ifetch_pcu.sv
// PC unit: one word PC per hardware thread, next-PC select and thread phase.
// Latency: PC and phase update on the clock edge where i_ena is high.
// Backpressure: holds everything while i_ena is low.
// Ports: clk_i/rst_ni (sync, active-low); i_ena advance; i_bra_taken and
// i_target redirect the current thread; i_msr_txe enables interleave;
// o_pha (1=thread0) and o_adr (current thread PC).
module aemb2_ifetch_pcu
    import aemb2_pkg::*;
#(
    parameter bit          TXE  = 1'b1,
    parameter logic [29:0] RPC0 = RPC0_DEF,
    parameter logic [29:0] RPC1 = RPC1_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_ena,
    input  logic        i_bra_taken,
    input  logic [29:0] i_target,
    input  logic        i_msr_txe,
    output logic        o_pha,
    output logic [29:0] o_adr
);

    logic [29:0] r_pc0;
    logic [29:0] r_pc1;
    logic        r_pha;
    logic [29:0] w_pc_cur;
    logic [29:0] w_pc_nxt;
    logic        w_interleave;

    assign w_pc_cur     = r_pha ? r_pc0 : r_pc1;
    // 30-bit add wraps the top word address back to zero.
    assign w_pc_nxt     = i_bra_taken ? i_target : w_pc_cur + 30'd1;
    assign w_interleave = TXE & i_msr_txe;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_pc0 <= RPC0;
            r_pc1 <= RPC1;
            r_pha <= 1'b1;
        end else if (i_ena) begin
            if (r_pha) r_pc0 <= w_pc_nxt;
            else       r_pc1 <= w_pc_nxt;
            // Without interleave, fall back to thread 0; thread 1's PC freezes.
            r_pha <= w_interleave ? ~r_pha : 1'b1;
        end
    end

    assign o_pha = r_pha;
    assign o_adr = w_pc_cur;

endmodule

// File: rtl/aemb2_ifetch.sv
// Instruction fetch: Wishbone classic ifetch, field split, phase and pipeline enable.
// Latency: one clock from ack (or held word) to the registered *_IF fields.
// Backpressure: dena_i low after ack parks the word in a hold register (HOLD, stb low).
// Ports: clk_i/rst_ni (sync, active-low); iwb_* instruction bus; dena_i downstream
// ready; rBRA/rRES_EX EX-stage branch; rMSR_TXE interleave enable; ena_o pipeline
// advance; pha_o thread phase; rPC_IF/rOPC_IF/rRD_IF/rRA_IF/rRB_IF/rIMM_IF fields.
module aemb2_ifetch
    import aemb2_pkg::*;
#(
    parameter bit          TXE  = 1'b1,
    parameter logic [29:0] RPC0 = RPC0_DEF,
    parameter logic [29:0] RPC1 = RPC1_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [29:0] iwb_adr_o,
    output logic        iwb_stb_o,
    input  logic        iwb_ack_i,
    input  logic [31:0] iwb_dat_i,
    input  logic        dena_i,
    input  logic [1:0]  rBRA,
    input  logic [31:0] rRES_EX,
    input  logic        rMSR_TXE,
    output logic        ena_o,
    output logic        pha_o,
    output logic [29:0] rPC_IF,
    output logic [5:0]  rOPC_IF,
    output logic [4:0]  rRD_IF,
    output logic [4:0]  rRA_IF,
    output logic [4:0]  rRB_IF,
    output logic [15:0] rIMM_IF
);

    if_state_t   r_state;
    if_state_t   w_state_nxt;
    logic        r_run;        // low for the first clock after reset so a late ack is dropped
    logic [31:0] r_hold;
    if_fields_t  r_if;
    logic [29:0] r_pc_if;
    logic        w_ack;
    logic        w_capture;
    logic [31:0] w_word;
    if_fields_t  w_if_nxt;
    logic        w_unused;

    // Target low bits are a byte offset inside the word and carry no meaning here.
    assign w_unused = ^rRES_EX[1:0];

    assign iwb_stb_o = r_run & (r_state == ST_FETCH);
    assign w_ack     = iwb_stb_o & iwb_ack_i;

    always_comb begin
        w_state_nxt = r_state;
        ena_o       = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (w_ack) begin
                    if (dena_i) begin
                        ena_o = 1'b1;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (dena_i) begin
                    ena_o       = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    assign w_word   = (r_state == ST_HOLD) ? r_hold : iwb_dat_i;
    // A taken branch with no delay slot kills the instruction being fetched.
    assign w_if_nxt = (rBRA == BRA_NODLY) ? IF_NOP : decode_word(w_word);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_FETCH;
            r_run   <= 1'b0;
            r_hold  <= '0;
            r_if    <= IF_NOP;
            r_pc_if <= '0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_state_nxt;
            if (w_capture) r_hold <= iwb_dat_i;
            if (ena_o) begin
                r_if    <= w_if_nxt;
                r_pc_if <= iwb_adr_o;
            end
        end
    end

    aemb2_ifetch_pcu #(
        .TXE  (TXE),
        .RPC0 (RPC0),
        .RPC1 (RPC1)
    ) u_pcu (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_ena       (ena_o),
        .i_bra_taken (rBRA[1]),
        .i_target    (rRES_EX[31:2]),
        .i_msr_txe   (rMSR_TXE),
        .o_pha       (pha_o),
        .o_adr       (iwb_adr_o)
    );

    assign rPC_IF  = r_pc_if;
    assign rOPC_IF = r_if.opc;
    assign rRD_IF  = r_if.rd;
    assign rRA_IF  = r_if.ra;
    assign rRB_IF  = r_if.rb;
    assign rIMM_IF = r_if.imm;

endmodule

// File: tb/tb_aemb2_ifetch.sv
// Bench for aemb2_ifetch: directed vector table followed by randomized traffic
// checked against a per-thread PC / hold-buffer reference model.
module tb_aemb2_ifetch;

    localparam logic [29:0] M_RPC0 = 30'h0;
    localparam logic [29:0] M_RPC1 = 30'h100;
    localparam logic [31:0] W_NOP  = 32'h8000_0000;   // opcode 6'o40, all other fields 0

    logic        clk;
    logic        rst_ni;
    logic [29:0] iwb_adr_o;
    logic        iwb_stb_o;
    logic        iwb_ack_i;
    logic [31:0] iwb_dat_i;
    logic        dena_i;
    logic [1:0]  rBRA;
    logic [31:0] rRES_EX;
    logic        rMSR_TXE;
    logic        ena_o;
    logic        pha_o;
    logic [29:0] rPC_IF;
    logic [5:0]  rOPC_IF;
    logic [4:0]  rRD_IF;
    logic [4:0]  rRA_IF;
    logic [4:0]  rRB_IF;
    logic [15:0] rIMM_IF;

    aemb2_ifetch dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .iwb_adr_o (iwb_adr_o),
        .iwb_stb_o (iwb_stb_o),
        .iwb_ack_i (iwb_ack_i),
        .iwb_dat_i (iwb_dat_i),
        .dena_i    (dena_i),
        .rBRA      (rBRA),
        .rRES_EX   (rRES_EX),
        .rMSR_TXE  (rMSR_TXE),
        .ena_o     (ena_o),
        .pha_o     (pha_o),
        .rPC_IF    (rPC_IF),
        .rOPC_IF   (rOPC_IF),
        .rRD_IF    (rRD_IF),
        .rRA_IF    (rRA_IF),
        .rRB_IF    (rRB_IF),
        .rIMM_IF   (rIMM_IF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        rst;
        bit        ack;
        bit        dena;
        bit [1:0]  bra;
        bit [31:0] res;
        bit        txe;
        bit [31:0] dat;
        bit        cc;       // check the pre-edge combinational outputs
        bit        e_stb;
        bit [29:0] e_adr;
        bit        e_ena;
        bit        e_pha;    // registered values after the edge
        bit [29:0] e_pcif;
        bit [31:0] e_word;   // instruction word whose fields must appear in IF
    } vec_t;

    vec_t tbl[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cur_row     = 0;

    // Reference model state
    bit [29:0] m_pc [2];
    int        m_thr;
    bit        m_hold;
    bit [31:0] m_hword;
    bit        m_run;
    bit [29:0] m_pcif;
    bit [31:0] m_word;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s row %0d: got %h expected %h", nm, cur_row, act, exp);
        end
    endtask

    task automatic add(input bit rst, input bit ack, input bit dena, input bit [1:0] bra,
                       input bit [31:0] res, input bit txe, input bit [31:0] dat, input bit cc,
                       input bit e_stb, input bit [29:0] e_adr, input bit e_ena,
                       input bit e_pha, input bit [29:0] e_pcif, input bit [31:0] e_word);
        vec_t v;
        v.rst = rst; v.ack = ack; v.dena = dena; v.bra = bra; v.res = res; v.txe = txe;
        v.dat = dat; v.cc = cc; v.e_stb = e_stb; v.e_adr = e_adr; v.e_ena = e_ena;
        v.e_pha = e_pha; v.e_pcif = e_pcif; v.e_word = e_word;
        tbl.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        rst_ni    = ~v.rst;
        iwb_ack_i = v.ack;
        dena_i    = v.dena;
        rBRA      = v.bra;
        rRES_EX   = v.res;
        rMSR_TXE  = v.txe;
        iwb_dat_i = v.dat;
        #1;
        if (v.cc) begin
            chk("stb", 32'(iwb_stb_o), 32'(v.e_stb));
            chk("adr", 32'(iwb_adr_o), 32'(v.e_adr));
            chk("ena", 32'(ena_o),     32'(v.e_ena));
        end
        @(posedge clk);
        #1;
        chk("pha",    32'(pha_o),   32'(v.e_pha));
        chk("pc_if",  32'(rPC_IF),  32'(v.e_pcif));
        chk("opc_if", 32'(rOPC_IF), 32'(v.e_word[31:26]));
        chk("rd_if",  32'(rRD_IF),  32'(v.e_word[25:21]));
        chk("ra_if",  32'(rRA_IF),  32'(v.e_word[20:16]));
        chk("rb_if",  32'(rRB_IF),  32'(v.e_word[15:11]));
        chk("imm_if", 32'(rIMM_IF), 32'(v.e_word[15:0]));
        cur_row++;
    endtask

    // Expected bus/enable outputs from the model state before the edge.
    task automatic model_comb(inout vec_t v);
        v.e_stb = m_run && !m_hold;
        v.e_adr = m_pc[m_thr];
        v.e_ena = v.dena && ((v.e_stb && v.ack) || m_hold);
    endtask

    // Advance the model across one clock edge and record expected IF contents.
    task automatic model_edge(inout vec_t v);
        if (v.rst) begin
            m_pc[0] = M_RPC0; m_pc[1] = M_RPC1; m_thr = 0;
            m_hold = 0; m_run = 0; m_pcif = '0; m_word = W_NOP;
        end else begin
            if (v.e_ena) begin
                m_word      = (v.bra == 2'b10) ? W_NOP : (m_hold ? m_hword : v.dat);
                m_pcif      = m_pc[m_thr];
                m_pc[m_thr] = v.bra[1] ? v.res[31:2] : m_pc[m_thr] + 30'd1;
                m_thr       = v.txe ? 1 - m_thr : 0;
                m_hold      = 0;
            end else if (v.e_stb && v.ack && !v.dena) begin
                m_hold  = 1;
                m_hword = v.dat;
            end
            m_run = 1;
        end
        v.e_pha  = (m_thr == 0);
        v.e_pcif = m_pcif;
        v.e_word = m_word;
    endtask

    initial begin
        rst_ni = 1'b0; iwb_ack_i = 1'b0; dena_i = 1'b1; rBRA = 2'b00;
        rRES_EX = '0; rMSR_TXE = 1'b0; iwb_dat_i = '0;
        m_pc[0] = M_RPC0; m_pc[1] = M_RPC1; m_thr = 0; m_hold = 0;
        m_hword = '0; m_run = 0; m_pcif = '0; m_word = W_NOP;

        //   rst ack dena bra    res            txe dat            cc stb adr         ena pha pcif        word
        // reset for three clocks, then release
        add(1, 0, 1, 2'b00, 32'h0,          0, 32'h0,          0, 0, 30'h0,       0,  1, 30'h0,       W_NOP);
        add(1, 0, 1, 2'b00, 32'h0,          0, 32'h0,          0, 0, 30'h0,       0,  1, 30'h0,       W_NOP);
        add(1, 0, 1, 2'b00, 32'h0,          0, 32'h0,          0, 0, 30'h0,       0,  1, 30'h0,       W_NOP);
        add(0, 0, 1, 2'b00, 32'h0,          0, 32'h0,          1, 0, 30'h0,       0,  1, 30'h0,       W_NOP);
        // single thread, ack every cycle
        add(0, 1, 1, 2'b00, 32'h0,          0, 32'h1111_1111,  1, 1, 30'h0,       1,  1, 30'h0,       32'h1111_1111);
        add(0, 1, 1, 2'b00, 32'h0,          0, 32'h2222_2222,  1, 1, 30'h1,       1,  1, 30'h1,       32'h2222_2222);
        add(0, 1, 1, 2'b00, 32'h0,          0, 32'h3333_3333,  1, 1, 30'h2,       1,  1, 30'h2,       32'h3333_3333);
        add(0, 1, 1, 2'b00, 32'h0,          0, 32'h4444_4444,  1, 1, 30'h3,       1,  1, 30'h3,       32'h4444_4444);
        // two wait states
        add(0, 0, 1, 2'b00, 32'h0,          0, 32'hDEAD_BEEF,  1, 1, 30'h4,       0,  1, 30'h3,       32'h4444_4444);
        add(0, 0, 1, 2'b00, 32'h0,          0, 32'hDEAD_BEEF,  1, 1, 30'h4,       0,  1, 30'h3,       32'h4444_4444);
        add(0, 1, 1, 2'b00, 32'h0,          0, 32'h5555_5555,  1, 1, 30'h4,       1,  1, 30'h4,       32'h5555_5555);
        // ack while downstream stalls for four clocks, then release
        add(0, 1, 0, 2'b00, 32'h0,          0, 32'h3062_0005,  1, 1, 30'h5,       0,  1, 30'h4,       32'h5555_5555);
        add(0, 0, 0, 2'b00, 32'h0,          0, 32'hDEAD_BEEF,  1, 0, 30'h5,       0,  1, 30'h4,       32'h5555_5555);
        add(0, 0, 0, 2'b00, 32'h0,          0, 32'hDEAD_BEEF,  1, 0, 30'h5,       0,  1, 30'h4,       32'h5555_5555);
        add(0, 0, 0, 2'b00, 32'h0,          0, 32'hDEAD_BEEF,  1, 0, 30'h5,       0,  1, 30'h4,       32'h5555_5555);
        add(0, 0, 1, 2'b00, 32'h0,          0, 32'hDEAD_BEEF,  1, 0, 30'h5,       1,  1, 30'h5,       32'h3062_0005);
        // branch without delay slot squashes, with delay slot keeps
        add(0, 1, 1, 2'b10, 32'h400,        0, 32'h6666_6666,  1, 1, 30'h6,       1,  1, 30'h6,       W_NOP);
        add(0, 1, 1, 2'b00, 32'h0,          0, 32'h7777_7777,  1, 1, 30'h100,     1,  1, 30'h100,     32'h7777_7777);
        add(0, 1, 1, 2'b11, 32'h800,        0, 32'h8888_8888,  1, 1, 30'h101,     1,  1, 30'h101,     32'h8888_8888);
        add(0, 1, 1, 2'b00, 32'h0,          0, 32'h9999_9999,  1, 1, 30'h200,     1,  1, 30'h200,     32'h9999_9999);
        // interleave on
        add(0, 1, 1, 2'b00, 32'h0,          1, 32'hAAAA_AAAA,  1, 1, 30'h201,     1,  0, 30'h201,     32'hAAAA_AAAA);
        add(0, 1, 1, 2'b00, 32'h0,          1, 32'hBBBB_BBBB,  1, 1, 30'h100,     1,  1, 30'h100,     32'hBBBB_BBBB);
        add(0, 1, 1, 2'b00, 32'h0,          1, 32'hCCCC_CCCC,  1, 1, 30'h202,     1,  0, 30'h202,     32'hCCCC_CCCC);
        add(0, 1, 1, 2'b00, 32'h0,          1, 32'hDDDD_DDDD,  1, 1, 30'h101,     1,  1, 30'h101,     32'hDDDD_DDDD);
        // reset in the middle of a wait, late ack ignored
        add(0, 0, 1, 2'b00, 32'h0,          1, 32'h0,          1, 1, 30'h203,     0,  1, 30'h101,     32'hDDDD_DDDD);
        add(1, 0, 1, 2'b00, 32'h0,          1, 32'h0,          1, 1, 30'h203,     0,  1, 30'h0,       W_NOP);
        add(0, 1, 1, 2'b00, 32'h0,          1, 32'hEEEE_EEEE,  1, 0, 30'h0,       0,  1, 30'h0,       W_NOP);
        add(0, 0, 1, 2'b00, 32'h0,          1, 32'h0,          1, 1, 30'h0,       0,  1, 30'h0,       W_NOP);
        // interleave from reset: RPC0, RPC1, RPC0+1, RPC1+1
        add(0, 1, 1, 2'b00, 32'h0,          1, 32'h0000_0001,  1, 1, 30'h0,       1,  0, 30'h0,       32'h0000_0001);
        add(0, 1, 1, 2'b00, 32'h0,          1, 32'h0000_0002,  1, 1, 30'h100,     1,  1, 30'h100,     32'h0000_0002);
        add(0, 1, 1, 2'b00, 32'h0,          1, 32'h0000_0003,  1, 1, 30'h1,       1,  0, 30'h1,       32'h0000_0003);
        add(0, 1, 1, 2'b00, 32'h0,          1, 32'h0000_0004,  1, 1, 30'h101,     1,  1, 30'h101,     32'h0000_0004);
        // interleave dropped while in thread-1 phase: phase returns to 1, PC1 frozen
        add(0, 1, 1, 2'b00, 32'h0,          1, 32'h0000_0005,  1, 1, 30'h2,       1,  0, 30'h2,       32'h0000_0005);
        add(0, 1, 1, 2'b00, 32'h0,          0, 32'h0000_0006,  1, 1, 30'h102,     1,  1, 30'h102,     32'h0000_0006);
        add(0, 1, 1, 2'b00, 32'h0,          0, 32'h0000_0007,  1, 1, 30'h3,       1,  1, 30'h3,       32'h0000_0007);
        add(0, 1, 1, 2'b00, 32'h0,          0, 32'h0000_0008,  1, 1, 30'h4,       1,  1, 30'h4,       32'h0000_0008);
        // branch to the top word (low target bits ignored), then wrap to zero
        add(0, 1, 1, 2'b10, 32'hFFFF_FFFF,  0, 32'h0000_0009,  1, 1, 30'h5,       1,  1, 30'h5,       W_NOP);
        add(0, 1, 1, 2'b00, 32'h0,          0, 32'h0000_1234,  1, 1, 30'h3FFFFFFF,1,  1, 30'h3FFFFFFF,32'h0000_1234);
        add(0, 1, 1, 2'b00, 32'h0,          0, 32'h0000_5678,  1, 1, 30'h0,       1,  1, 30'h0,       32'h0000_5678);

        #1;
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Randomized traffic against the reference model.
        begin
            bit txe_r;
            txe_r = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                vec_t v;
                if ($urandom_range(0, 19) == 0) txe_r = ~txe_r;
                v.rst  = (n < 2) || ($urandom_range(0, 199) == 0);
                v.ack  = ($urandom_range(0, 2) != 0);
                v.dena = ($urandom_range(0, 3) != 0);
                v.bra  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'b00;
                v.res  = $urandom;
                v.txe  = txe_r;
                v.dat  = $urandom;
                v.cc   = (n != 0);
                model_comb(v);
                model_edge(v);
                apply(v);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
